// File: rtl/ula_seq.sv
// Clocked ALU with start/busy/done handshake; MUL (shift-add) and DIV (restoring) take
// WIDTH cycles, everything else completes on the accepting edge. Result drives 7-seg digits.
module ula_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [2:0]            sel,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [WIDTH-1:0]      rem,
  output logic [3:0]            flags,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_HOLD = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Active-low 7-segment pattern {a..g} for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b1100000;
      4'hC:    pat = 7'b0110001;
      4'hD:    pat = 7'b1000010;
      4'hE:    pat = 7'b0110000;
      4'hF:    pat = 7'b0111000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   op_mul_q, op_mul_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;   // multiplier (MUL) or dividend/quotient (DIV)
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;       // product (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0]       result_q, result_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [3:0]             flags_q, flags_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic [WIDTH:0]         add_s, sub_s;
  logic [2*WIDTH-1:0]     mul_acc_s;
  logic [WIDTH:0]         div_shift_s, div_diff_s;
  logic                   div_ge_s;
  logic [WIDTH-1:0]       div_rem_s, div_quo_s;

  assign add_s       = {1'b0, a} + {1'b0, b};
  assign sub_s       = {1'b0, a} - {1'b0, b};
  assign mul_acc_s   = shreg_q[0] ? (acc_q + mcand_q) : acc_q;
  assign div_shift_s = {acc_q[WIDTH-1:0], shreg_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opb_q};
  // Partial remainder stays below 2*b, so the difference sign bit is a clean compare
  assign div_ge_s    = ~div_diff_s[WIDTH];
  assign div_rem_s   = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
  assign div_quo_s   = {shreg_q[WIDTH-2:0], div_ge_s};

  // Next-state, datapath iteration and output update
  always_comb begin
    logic wr_s, dz_s, ovf_s, cy_s;
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_mul_d = op_mul_q;
    shreg_d  = shreg_q;
    opb_d    = opb_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    wr_s     = 1'b0;
    dz_s     = 1'b0;
    ovf_s    = 1'b0;
    cy_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          wr_s  = 1'b1;
          rem_d = {WIDTH{1'b0}};
          case (sel)
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_ADD: begin
              result_d = add_s[WIDTH-1:0];
              cy_s     = add_s[WIDTH];
              ovf_s    = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              result_d = sub_s[WIDTH-1:0];
              cy_s     = sub_s[WIDTH];
              ovf_s    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL, OP_DIV: begin
              if ((sel == OP_DIV) && (b == {WIDTH{1'b0}})) begin
                result_d = {WIDTH{1'b1}};
                rem_d    = a;
                dz_s     = 1'b1;
              end else begin
                wr_s     = 1'b0;
                rem_d    = rem_q;
                state_d  = EXEC;
                busy_d   = 1'b1;
                cnt_d    = {CW{1'b0}};
                op_mul_d = (sel == OP_MUL);
                shreg_d  = (sel == OP_MUL) ? b : a;
                opb_d    = b;
                mcand_d  = {{WIDTH{1'b0}}, a};
                acc_d    = {(2*WIDTH){1'b0}};
              end
            end
            OP_HOLD: begin
              result_d = result_q;
              rem_d    = rem_q;
            end
            default: begin
              result_d = result_q;
              rem_d    = rem_q;
            end
          endcase
        end else begin
          wr_s = 1'b0;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (op_mul_q) begin
          acc_d   = mul_acc_s;
          mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end else begin
          acc_d   = {{WIDTH{1'b0}}, div_rem_s};
          shreg_d = div_quo_s;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          wr_s    = 1'b1;
          state_d = IDLE;
          busy_d  = 1'b0;
          if (op_mul_q) begin
            result_d = mul_acc_s[WIDTH-1:0];
            rem_d    = {WIDTH{1'b0}};
            cy_s     = |mul_acc_s[2*WIDTH-1:WIDTH];
          end else begin
            result_d = div_quo_s;
            rem_d    = div_rem_s;
          end
        end else begin
          wr_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (wr_s) begin
      done_d  = 1'b1;
      flags_d = {dz_s, ovf_s, cy_s, (result_d == {WIDTH{1'b0}})};
    end else begin
      done_d  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      op_mul_q <= 1'b0;
      shreg_q  <= {WIDTH{1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      result_q <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      flags_q  <= 4'b0000;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_mul_q <= op_mul_d;
      shreg_q  <= shreg_d;
      opb_q    <= opb_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Hex decode of the registered result, one digit per nibble
  always_comb begin
    seg = {(7*DIGITS){1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = hex7(result_q[4*i +: 4]);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rem    = rem_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (WIDTH=8): reset, single-cycle ops, MUL/DIV latency, back-to-back.
module tb_ula_seq;

  localparam int W = 8;

  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_HOLD = 3'd7;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a     = 8'h00;
  logic [W-1:0] b     = 8'h00;
  logic [2:0]   sel   = 3'd0;
  logic         start = 1'b0;
  logic         busy, done;
  logic [W-1:0] result, rem;
  logic [3:0]   flags;
  logic [13:0]  seg;

  int n_chk  = 0;
  int n_fail = 0;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .start(start),
    .busy(busy), .done(done), .result(result), .rem(rem), .flags(flags), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    sel = s; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int seen;
    int early;
    int pulses;

    // 1: reset state, then reset in the middle of a MUL
    #2;
    chk("rst_busy",   busy,   1'b0);
    chk("rst_done",   done,   1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_rem",    rem,    8'h00);
    chk("rst_flags",  flags,  4'h0);
    chk("rst_seg",    seg,    {7'b0000001, 7'b0000001});
    step();
    rst_n = 1'b1;
    step();
    go(OP_MUL, 8'h03, 8'h05);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   busy,   1'b0);
    chk("midrst_result", result, 8'h00);
    chk("midrst_flags",  flags,  4'h0);
    chk("midrst_seg",    seg,    {7'b0000001, 7'b0000001});
    step(); step(); step();
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (done) seen = 1;
    end
    chk("no_done_after_rst", seen, 0);

    // 2: ADD with carry-out
    go(OP_ADD, 8'hF0, 8'h20);
    chk("add_done",   done,   1'b1);
    chk("add_result", result, 8'h10);
    chk("add_flags",  flags,  4'b0010);
    chk("add_rem",    rem,    8'h00);
    chk("add_seg1",   seg[13:7], 7'b1001111);
    chk("add_seg0",   seg[6:0],  7'b0000001);
    step();
    chk("add_done_pulse", done, 1'b0);

    // 3: SUB signed overflow, SUB to zero
    go(OP_SUB, 8'h80, 8'h01);
    chk("sub_ovf_result", result, 8'h7F);
    chk("sub_ovf_flags",  flags,  4'b0100);
    go(OP_SUB, 8'h05, 8'h05);
    chk("sub_zero_result", result, 8'h00);
    chk("sub_zero_flags",  flags,  4'b0001);
    go(OP_SUB, 8'h03, 8'h05);
    chk("sub_borrow_result", result, 8'hFE);
    chk("sub_borrow_flags",  flags,  4'b0010);

    // 4: MUL latency, with start pulses and operand changes while busy
    go(OP_MUL, 8'h13, 8'h11);
    chk("mul_busy", busy, 1'b1);
    chk("mul_nodone", done, 1'b0);
    start = 1'b1; a = 8'hFF; b = 8'hFF; sel = OP_ADD;
    early = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8 && (done || !busy)) early = 1;
      if (i == 6) start = 1'b0;
    end
    chk("mul_early", early, 0);
    chk("mul_done8", done,  1'b1);
    chk("mul_busy0", busy,  1'b0);
    chk("mul_result", result, 8'h43);
    chk("mul_flags",  flags,  4'b0010);
    chk("mul_rem",    rem,    8'h00);
    chk("mul_seg",    seg,    {7'b1001100, 7'b0000110});
    step();
    chk("mul_done_pulse", done, 1'b0);

    // 5: DIV iterative, then divide by zero
    go(OP_DIV, 8'hC8, 8'h07);
    early = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 8 && done) early = 1;
    end
    chk("div_early",  early,  0);
    chk("div_done8",  done,   1'b1);
    chk("div_result", result, 8'h1C);
    chk("div_rem",    rem,    8'h04);
    chk("div_flags",  flags,  4'b0000);
    go(OP_DIV, 8'h2A, 8'h00);
    chk("dz_done",   done,   1'b1);
    chk("dz_busy",   busy,   1'b0);
    chk("dz_result", result, 8'hFF);
    chk("dz_rem",    rem,    8'h2A);
    chk("dz_flags",  flags,  4'b1000);

    // 6: start held high: ADD, MUL in ADD's done cycle, then HOLD
    pulses = 0;
    sel = OP_ADD; a = 8'h01; b = 8'h02; start = 1'b1;
    step();
    pulses += done;
    chk("b2b_add_result", result, 8'h03);
    sel = OP_MUL; a = 8'h04; b = 8'h05;
    step();
    pulses += done;
    chk("b2b_mul_busy", busy, 1'b1);
    sel = OP_HOLD; a = 8'hFF; b = 8'hFF;
    for (int i = 1; i <= 8; i++) begin
      step();
      pulses += done;
    end
    chk("b2b_mul_result", result, 8'h14);
    step();
    pulses += done;
    start = 1'b0;
    chk("b2b_hold_done",   done,   1'b1);
    chk("b2b_hold_result", result, 8'h14);
    chk("b2b_hold_rem",    rem,    8'h00);
    chk("b2b_hold_flags",  flags,  4'b0000);
    step();
    pulses += done;
    chk("b2b_pulses", pulses, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
